acumulador_digitos_teclado: RTL and testbench

- Downstream stage of the 10-key priority encoder; consumes its 4-bit BCD code and active-low valid flag.
- Debounces each key press and registers exactly one digit per press/release cycle.
- Shifts accepted digits into a multi-digit BCD buffer (newest digit in the least significant nibble) for display/compare logic further down.

---
 rtl/acumulador_digitos_teclado.sv | 145 ++++++++++++++
 tb/tb_acumulador_digitos_teclado.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/acumulador_digitos_teclado.sv
// Debounced BCD keypad digit accumulator: one digit per press/release, newest digit in nibble 0.
// Optional APAGAR_EN macro adds an 'apagar' (backspace) input that drops the newest digit.
module acumulador_digitos_teclado #(
    parameter int unsigned NUM_DIGITOS    = 4,
    parameter int unsigned ESTAVEL_CICLOS = 3
) (
    input  logic                               clk,
    input  logic                               resetN,
    input  logic [3:0]                         entradaBCD,
    input  logic                               dadoValidoN,
    input  logic                               limpar,
`ifdef APAGAR_EN
    input  logic                               apagar,
`endif
    output logic [4*NUM_DIGITOS-1:0]           digitos,
    output logic [$clog2(NUM_DIGITOS+1)-1:0]   quantidade,
    output logic                               cheio,
    output logic                               novoDigito,
    output logic                               transbordo
);

    localparam int unsigned DW = 4 * NUM_DIGITOS;
    localparam int unsigned QW = $clog2(NUM_DIGITOS + 1);
    localparam int unsigned CW = $clog2(ESTAVEL_CICLOS);
    localparam logic [CW-1:0] CntMax = CW'(ESTAVEL_CICLOS - 1);
    localparam logic [QW-1:0] QtdMax = QW'(NUM_DIGITOS);

    typedef enum logic [1:0] {Ocioso, Confirmando, Pressionado, Soltando} estadoT;

    estadoT          estadoQ, estadoD;
    logic [CW-1:0]   cntQ, cntD;
    logic [3:0]      capturadoQ, capturadoD;
    logic [DW-1:0]   digitosQ, digitosD;
    logic [QW-1:0]   quantidadeQ, quantidadeD;
    logic            novoQ, novoD;
    logic            transbordoQ, transbordoD;
    logic            aceitar;
    logic            cheioQ;
    logic            apagarIn;

`ifdef APAGAR_EN
    assign apagarIn = apagar;
`else
    assign apagarIn = 1'b0;
`endif

    assign cheioQ = (quantidadeQ == QtdMax);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            estadoQ     <= Ocioso;
            cntQ        <= '0;
            capturadoQ  <= '0;
            digitosQ    <= '0;
            quantidadeQ <= '0;
            novoQ       <= 1'b0;
            transbordoQ <= 1'b0;
        end else begin
            estadoQ     <= estadoD;
            cntQ        <= cntD;
            capturadoQ  <= capturadoD;
            digitosQ    <= digitosD;
            quantidadeQ <= quantidadeD;
            novoQ       <= novoD;
            transbordoQ <= transbordoD;
        end
    end

    always_comb begin
        estadoD    = estadoQ;
        cntD       = cntQ;
        capturadoD = capturadoQ;
        aceitar    = 1'b0;
        unique case (estadoQ)
            Ocioso: begin
                // Codes 10-15 are not digits and never start a debounce.
                if (!dadoValidoN && (entradaBCD <= 4'd9)) begin
                    capturadoD = entradaBCD;
                    cntD       = CW'(1);
                    estadoD    = Confirmando;
                end
            end
            Confirmando: begin
                if (dadoValidoN || (entradaBCD != capturadoQ)) begin
                    cntD    = '0;
                    estadoD = Ocioso;
                end else if (cntQ == CntMax) begin
                    aceitar = 1'b1;
                    cntD    = '0;
                    estadoD = Pressionado;
                end else begin
                    cntD = cntQ + CW'(1);
                end
            end
            Pressionado: begin
                if (dadoValidoN) begin
                    cntD    = CW'(1);
                    estadoD = Soltando;
                end
            end
            Soltando: begin
                if (!dadoValidoN) begin
                    cntD    = '0;
                    estadoD = Pressionado;
                end else if (cntQ == CntMax) begin
                    cntD    = '0;
                    estadoD = Ocioso;
                end else begin
                    cntD = cntQ + CW'(1);
                end
            end
            default: estadoD = Ocioso;
        endcase
    end

    // Priority: limpar, then an accepted press, then apagar.
    always_comb begin
        digitosD    = digitosQ;
        quantidadeD = quantidadeQ;
        novoD       = 1'b0;
        transbordoD = 1'b0;
        if (limpar) begin
            digitosD    = '0;
            quantidadeD = '0;
        end else if (aceitar) begin
            if (cheioQ) begin
                transbordoD = 1'b1;
            end else begin
                digitosD    = (digitosQ << 4) | DW'(capturadoQ);
                quantidadeD = quantidadeQ + QW'(1);
                novoD       = 1'b1;
            end
        end else if (apagarIn && (quantidadeQ != '0)) begin
            digitosD    = digitosQ >> 4;
            quantidadeD = quantidadeQ - QW'(1);
        end
    end

    assign digitos    = digitosQ;
    assign quantidade = quantidadeQ;
    assign cheio      = cheioQ;
    assign novoDigito = novoQ;
    assign transbordo = transbordoQ;

endmodule

// File: tb/tb_acumulador_digitos_teclado.sv
// Directed self-checking bench for acumulador_digitos_teclado (default parameters).
// Backspace steps run only when APAGAR_EN is defined.
module tb_acumulador_digitos_teclado;

    logic        clk = 1'b0;
    logic        resetN;
    logic [3:0]  entradaBCD;
    logic        dadoValidoN;
    logic        limpar;
    logic        apagar;
    logic [15:0] digitos;
    logic [2:0]  quantidade;
    logic        cheio;
    logic        novoDigito;
    logic        transbordo;

    int nChecks = 0;
    int nErrors = 0;
    int nNovo   = 0;
    int nTrans  = 0;
    int base;

    always #5 clk = ~clk;

    acumulador_digitos_teclado #(
        .NUM_DIGITOS   (4),
        .ESTAVEL_CICLOS(3)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .entradaBCD (entradaBCD),
        .dadoValidoN(dadoValidoN),
        .limpar     (limpar),
`ifdef APAGAR_EN
        .apagar     (apagar),
`endif
        .digitos    (digitos),
        .quantidade (quantidade),
        .cheio      (cheio),
        .novoDigito (novoDigito),
        .transbordo (transbordo)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (novoDigito) nNovo++;
        if (transbordo) nTrans++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        dadoValidoN = 1'b0;
        entradaBCD  = code;
        repeat (5) tick();
        dadoValidoN = 1'b1;
        repeat (5) tick();
    endtask

    task automatic clear();
        limpar = 1'b1;
        tick();
        limpar = 1'b0;
    endtask

    initial begin
        resetN      = 1'b0;
        entradaBCD  = 4'd0;
        dadoValidoN = 1'b1;
        limpar      = 1'b0;
        apagar      = 1'b0;
        repeat (2) tick();
        chk("rst_digitos", 32'(digitos), 32'h0);
        chk("rst_quantidade", 32'(quantidade), 32'd0);
        chk("rst_cheio", 32'(cheio), 32'd0);
        chk("rst_novo", 32'(novoDigito), 32'd0);
        chk("rst_transbordo", 32'(transbordo), 32'd0);
        resetN = 1'b1;

        // Key 5 accepted on the third stable edge.
        dadoValidoN = 1'b0;
        entradaBCD  = 4'd5;
        tick();
        tick();
        chk("pre_accept_qtd", 32'(quantidade), 32'd0);
        chk("pre_accept_novo", 32'(novoDigito), 32'd0);
        tick();
        chk("accept5_digitos", 32'(digitos), 32'h0005);
        chk("accept5_qtd", 32'(quantidade), 32'd1);
        chk("accept5_novo", 32'(novoDigito), 32'd1);
        tick();
        chk("novo_one_cycle", 32'(novoDigito), 32'd0);
        dadoValidoN = 1'b1;
        repeat (5) tick();
        clear();
        chk("clear_digitos", 32'(digitos), 32'h0);
        chk("clear_qtd", 32'(quantidade), 32'd0);

        // Bounce: never three stable samples.
        base = nNovo;
        entradaBCD  = 4'd4;
        dadoValidoN = 1'b0; tick(); tick();
        dadoValidoN = 1'b1; tick();
        dadoValidoN = 1'b0; tick(); tick();
        dadoValidoN = 1'b1; repeat (4) tick();
        chk("bounce_qtd", 32'(quantidade), 32'd0);
        chk("bounce_novo", 32'(nNovo - base), 32'd0);

        // Non-digit codes ignored.
        dadoValidoN = 1'b0;
        entradaBCD  = 4'd12;
        repeat (6) tick();
        dadoValidoN = 1'b1;
        tick();
        chk("code12_qtd", 32'(quantidade), 32'd0);

        // Fill buffer then overflow.
        base = nNovo;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("fill_digitos", 32'(digitos), 32'h1234);
        chk("fill_qtd", 32'(quantidade), 32'd4);
        chk("fill_cheio", 32'(cheio), 32'd1);
        chk("fill_novo_cnt", 32'(nNovo - base), 32'd4);
        base = nNovo;
        dadoValidoN = 1'b0;
        entradaBCD  = 4'd7;
        repeat (3) tick();
        chk("ovf_transbordo", 32'(transbordo), 32'd1);
        chk("ovf_novo", 32'(novoDigito), 32'd0);
        tick();
        chk("ovf_pulse_end", 32'(transbordo), 32'd0);
        dadoValidoN = 1'b1;
        repeat (5) tick();
        chk("ovf_digitos", 32'(digitos), 32'h1234);
        chk("ovf_trans_cnt", 32'(nTrans), 32'd1);
        chk("ovf_novo_cnt", 32'(nNovo - base), 32'd0);

        // Long hold with code change: single digit.
        clear();
        base = nNovo;
        dadoValidoN = 1'b0;
        entradaBCD  = 4'd9;
        repeat (10) tick();
        entradaBCD  = 4'd8;
        repeat (10) tick();
        dadoValidoN = 1'b1;
        repeat (5) tick();
        chk("hold_novo_cnt", 32'(nNovo - base), 32'd1);
        chk("hold_digitos", 32'(digitos), 32'h0009);

        // limpar on the accept edge wins.
        clear();
        press(4'd1); press(4'd2);
        chk("pre_clr_digitos", 32'(digitos), 32'h0012);
        base = nNovo;
        dadoValidoN = 1'b0;
        entradaBCD  = 4'd6;
        tick(); tick();
        limpar = 1'b1;
        tick();
        limpar = 1'b0;
        chk("clr_acc_digitos", 32'(digitos), 32'h0);
        chk("clr_acc_qtd", 32'(quantidade), 32'd0);
        chk("clr_acc_novo", 32'(novoDigito), 32'd0);
        repeat (4) tick();
        chk("clr_held_no_reaccept", 32'(nNovo - base), 32'd0);
        dadoValidoN = 1'b1;
        repeat (5) tick();
        press(4'd3);
        chk("after_clr_digitos", 32'(digitos), 32'h0003);
        chk("after_clr_qtd", 32'(quantidade), 32'd1);

`ifdef APAGAR_EN
        clear();
        press(4'd1); press(4'd2); press(4'd3);
        chk("bs_pre", 32'(digitos), 32'h0123);
        apagar = 1'b1;
        tick();
        apagar = 1'b0;
        chk("bs_digitos", 32'(digitos), 32'h0012);
        chk("bs_qtd", 32'(quantidade), 32'd2);
        clear();
        apagar = 1'b1;
        tick();
        apagar = 1'b0;
        chk("bs_empty_digitos", 32'(digitos), 32'h0);
        chk("bs_empty_qtd", 32'(quantidade), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
